// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage owning the PC, one outstanding imem
// request and a single hold register feeding the enable-less IF/ID register.
//
// Ports:
//   clk, rst (async, active-high)
//   stall, redirect, redirect_pc   : hazard / control-flow inputs from ID/EX
//   imem_req, imem_addr            : request strobe and address (always accepted)
//   imem_ack, imem_rdata           : one-cycle response pulse and data
//   PR0_valid, PR0_PC_plus1,
//   PR0_instruction_in             : hand-off to IF/ID, all-zero bubble otherwise
//
// Optional feature: define IF_PREFETCH_EN to issue the next request in the
// same cycle an instruction is consumed (2 cycles/instr on 1-cycle memory).
module if_fetch_unit #(
    parameter int                ADDR_W   = 12,
    parameter int                INSTR_W  = 19,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               PR0_valid,
    output logic [ADDR_W-1:0]  PR0_PC_plus1,
    output logic [INSTR_W-1:0] PR0_instruction_in
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HAVE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               kill_q, kill_d;
    logic [INSTR_W-1:0] hold_instr_q, hold_instr_d;
    logic [ADDR_W-1:0]  hold_pc1_q, hold_pc1_d;

    logic [ADDR_W-1:0]  pc_inc;
    logic               consume;

    // Wraps modulo 2^ADDR_W by construction.
    assign pc_inc  = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    assign consume = (state_q == S_HAVE) & ~stall & ~redirect;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            hold_instr_q <= '0;
            hold_pc1_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            hold_instr_q <= hold_instr_d;
            hold_pc1_q   <= hold_pc1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        hold_instr_d = hold_instr_q;
        hold_pc1_d   = hold_pc1_q;
        unique case (state_q)
            S_REQ: begin
                // A stray ack here belongs to a request abandoned by reset.
                if (redirect) begin
                    pc_d = redirect_pc;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    kill_d = 1'b0;
                    if (kill_q | redirect) begin
                        state_d = S_REQ;
                        if (redirect) begin
                            pc_d = redirect_pc;
                        end
                    end else begin
                        hold_instr_d = imem_rdata;
                        hold_pc1_d   = pc_inc;
                        state_d      = S_HAVE;
                    end
                end else if (redirect) begin
                    // Request is in flight: remember to drop its response.
                    pc_d   = redirect_pc;
                    kill_d = 1'b1;
                end
            end
            S_HAVE: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (!stall) begin
                    pc_d = pc_inc;
`ifdef IF_PREFETCH_EN
                    state_d = S_WAIT;
`else
                    state_d = S_REQ;
`endif
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // Outputs are forced to zero while reset is held, not just after it.
    always_comb begin
        imem_req           = 1'b0;
        imem_addr          = '0;
        PR0_valid          = 1'b0;
        PR0_PC_plus1       = '0;
        PR0_instruction_in = '0;
        if (!rst) begin
            imem_addr = pc_q;
            if (state_q == S_REQ) begin
                imem_req = ~redirect;
            end
`ifdef IF_PREFETCH_EN
            if (consume) begin
                imem_req  = 1'b1;
                imem_addr = pc_inc;
            end
`endif
            PR0_valid = consume;
            if (consume) begin
                PR0_PC_plus1       = hold_pc1_q;
                PR0_instruction_in = hold_instr_q;
            end
        end
    end

endmodule
